// File: rtl/read_src_fsm_if.sv
// ============================================================================
// Module   : read_src_fsm_if
// Purpose  : Bus bundle for the DMA source-side read engine. Carries the
//            AXI-MM read address channel, the read data channel and the
//            push side of the DMA data FIFO.
// Modports : master - read engine (drives AR, rready and FIFO push)
//            slave  - memory fabric / FIFO side
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface read_src_fsm_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 512,
  parameter int LEN_W  = 8
) ();
  // AR channel
  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;
  logic [LEN_W-1:0]  arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  // R channel
  logic              rvalid;
  logic              rready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  // FIFO push side
  logic              fifo_almost_full;
  logic              fifo_wr_en;
  logic [DATA_W-1:0] fifo_wr_data;

  modport master (
    output arvalid, araddr, arlen, arsize, arburst,
    input  arready,
    input  rvalid, rdata, rresp, rlast,
    output rready,
    input  fifo_almost_full,
    output fifo_wr_en, fifo_wr_data
  );

  modport slave (
    input  arvalid, araddr, arlen, arsize, arburst,
    output arready,
    output rvalid, rdata, rresp, rlast,
    input  rready,
    output fifo_almost_full,
    input  fifo_wr_en, fifo_wr_data
  );
endinterface

`default_nettype wire

// File: rtl/read_src_fsm.sv
// ============================================================================
// Module   : read_src_fsm
// Purpose  : Source-side read engine of the PIM DMA datapath. On a descriptor
//            go it issues one AXI-MM INCR read burst and pushes every OKAY
//            data beat straight into the DMA data FIFO. Reports done / error.
// Ports    : clk, reset          - clock, async active-high reset
//            go, src_addr, length - descriptor launch (sampled in IDLE only)
//            reset_dispatcher     - clears ERROR back to IDLE
//            bus (master)         - AR / R channels and FIFO push
//            busy, rd_fsm_done, rd_error, beat_count - status
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module read_src_fsm #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 512,
  parameter int LEN_W  = 8
) (
  input  wire logic              clk,
  input  wire logic              reset,
  input  wire logic              go,
  input  wire logic [ADDR_W-1:0] src_addr,
  input  wire logic [LEN_W-1:0]  length,
  input  wire logic              reset_dispatcher,
  read_src_fsm_if.master         bus,
  output logic                   busy,
  output logic                   rd_fsm_done,
  output logic                   rd_error,
  output logic [LEN_W:0]         beat_count
);

  localparam int             ARSIZE  = $clog2(DATA_W / 8);
  localparam logic [LEN_W:0] CNT_MAX = {1'b1, {LEN_W{1'b0}}};

  typedef enum logic [2:0] {
    IDLE           = 3'd0,
    ADDR_SETUP     = 3'd1,
    RD_SRC_WR_FIFO = 3'd2,
    DONE           = 3'd3,
    ERROR          = 3'd4
  } state_t;

  state_t            state;
  logic              arvalid_q;
  logic [ADDR_W-1:0] araddr_q;
  logic [LEN_W-1:0]  arlen_q;
  logic              err_flag;

  logic              rready;
  logic              beat;
  logic              resp_err;
  logic [LEN_W:0]    exp_beats;
  logic [LEN_W:0]    cnt_inc;
  logic              overrun;

  assign bus.arvalid = arvalid_q;
  assign bus.araddr  = araddr_q;
  assign bus.arlen   = arlen_q;
  assign bus.arsize  = 3'(ARSIZE);
  assign bus.arburst = 2'b01;

  // Back-pressure passes straight through; the FIFO guarantees a free slot
  // for the beat accepted in the same cycle almost_full rises.
  assign rready   = (state == RD_SRC_WR_FIFO) && !bus.fifo_almost_full;
  assign bus.rready = rready;
  assign beat     = bus.rvalid && rready;
  assign resp_err = (bus.rresp == 2'b10) || (bus.rresp == 2'b11);

  // Zero-latency push: error beats are consumed but never written.
  assign bus.fifo_wr_en   = beat && !resp_err;
  assign bus.fifo_wr_data = bus.rdata;

  assign exp_beats = (LEN_W+1)'(arlen_q) + (LEN_W+1)'(1);
  assign cnt_inc   = (beat_count == CNT_MAX) ? beat_count : beat_count + (LEN_W+1)'(1);
  // All expected beats already seen: any further beat is a protocol fault,
  // including an rlast that would otherwise match a saturated count.
  assign overrun   = (beat_count >= exp_beats);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      arvalid_q   <= 1'b0;
      araddr_q    <= '0;
      arlen_q     <= '0;
      err_flag    <= 1'b0;
      busy        <= 1'b0;
      rd_fsm_done <= 1'b0;
      rd_error    <= 1'b0;
      beat_count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (go) begin
            araddr_q   <= src_addr;
            arlen_q    <= length;
            beat_count <= '0;
            err_flag   <= 1'b0;
            arvalid_q  <= 1'b1;
            busy       <= 1'b1;
            state      <= ADDR_SETUP;
          end
        end
        ADDR_SETUP: begin
          if (bus.arready) begin
            arvalid_q <= 1'b0;
            state     <= RD_SRC_WR_FIFO;
          end
        end
        RD_SRC_WR_FIFO: begin
          if (beat) begin
            beat_count <= cnt_inc;
            if (resp_err) begin
              err_flag <= 1'b1;
            end
            if (bus.rlast) begin
              if (err_flag || resp_err || overrun || (cnt_inc != exp_beats)) begin
                rd_error <= 1'b1;
                state    <= ERROR;
              end else begin
                rd_fsm_done <= 1'b1;
                state       <= DONE;
              end
            end else if (overrun) begin
              rd_error <= 1'b1;
              state    <= ERROR;
            end
          end
        end
        DONE: begin
          rd_fsm_done <= 1'b0;
          busy        <= 1'b0;
          state       <= IDLE;
        end
        ERROR: begin
          if (reset_dispatcher) begin
            rd_error <= 1'b0;
            busy     <= 1'b0;
            state    <= IDLE;
          end
        end
        default: begin
          arvalid_q   <= 1'b0;
          busy        <= 1'b0;
          rd_fsm_done <= 1'b0;
          rd_error    <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_read_src_fsm.sv
// ============================================================================
// Module   : tb_read_src_fsm
// Purpose  : Self-checking bench for read_src_fsm. A table of burst records
//            (stimulus plus hand-computed results) drives a small fabric
//            model; hand-written sequences cover back-to-back launch, go
//            while busy and asynchronous reset in the data phase.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_read_src_fsm;
  localparam int ADDR_W = 64;
  localparam int DATA_W = 512;
  localparam int LEN_W  = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              go;
  logic [ADDR_W-1:0] src_addr;
  logic [LEN_W-1:0]  length;
  logic              reset_dispatcher;
  logic              busy;
  logic              rd_fsm_done;
  logic              rd_error;
  logic [LEN_W:0]    beat_count;

  read_src_fsm_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();

  read_src_fsm #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk              (clk),
    .reset            (reset),
    .go               (go),
    .src_addr         (src_addr),
    .length           (length),
    .reset_dispatcher (reset_dispatcher),
    .bus              (bus),
    .busy             (busy),
    .rd_fsm_done      (rd_fsm_done),
    .rd_error         (rd_error),
    .beat_count       (beat_count)
  );

  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [511:0] pat(input int s, input int b);
    logic [511:0] r;
    for (int k = 0; k < 16; k++) r[k*32 +: 32] = 32'hC0DE_0000 + 32'(s*256 + b*16 + k);
    return r;
  endfunction

  typedef struct {
    logic [63:0] addr;
    logic [7:0]  len;
    int          ar_delay;    // cycles arready is held low
    bit          afull_tog;   // almost_full 2 cycles on / 2 off
    int          err_beat;    // beat index carrying SLVERR, -1 none
    int          nbeats;      // beats presented by the fabric
    bit          rlast_final; // rlast on the final presented beat
    int          exp_push;
    bit          exp_done;
    bit          exp_err;
    logic [8:0]  exp_bc;
  } vec_t;

  vec_t tbl[6];

  task automatic run_vec(input vec_t v, input int idx);
    int b = 0;
    int pushes = 0;
    int cyc;
    logic afull;
    @(negedge clk);
    go = 1'b1; src_addr = v.addr; length = v.len; bus.arready = 1'b0;
    #1 check("idle_busy", busy, 0);
    @(negedge clk);
    go = 1'b0;
    for (cyc = 0; cyc < 30; cyc++) begin
      bus.arready = (cyc >= v.ar_delay);
      #1;
      check("arvalid", bus.arvalid, 1);
      check("araddr", bus.araddr, v.addr);
      check("arlen", bus.arlen, v.len);
      check("arsize", bus.arsize, 6);
      check("arburst", bus.arburst, 1);
      check("rready_pre_ar", bus.rready, 0);
      if (bus.arready) break;
      @(negedge clk);
    end
    for (cyc = 0; cyc < 100 && b < v.nbeats; cyc++) begin
      @(negedge clk);
      bus.arready = 1'b0;
      afull = v.afull_tog ? ((cyc / 2) % 2 == 0) : 1'b0;
      bus.fifo_almost_full = afull;
      bus.rvalid = 1'b1;
      bus.rdata  = pat(idx, b);
      bus.rresp  = (b == v.err_beat) ? 2'd2 : 2'd0;
      bus.rlast  = v.rlast_final && (b == v.nbeats - 1);
      #1;
      if (cyc == 0) check("arvalid_drop", bus.arvalid, 0);
      check("rready", bus.rready, !afull);
      if (bus.fifo_wr_en) pushes++;
      if (!afull) begin
        if (bus.rresp == 2'd0) begin
          check("wr_en", bus.fifo_wr_en, 1);
          check("wr_data", bus.fifo_wr_data, pat(idx, b));
        end else begin
          check("wr_en_err", bus.fifo_wr_en, 0);
        end
        b++;
      end else begin
        check("wr_en_stall", bus.fifo_wr_en, 0);
      end
    end
    check("beats_taken", b, v.nbeats);
    @(negedge clk);
    bus.rvalid = 1'b0; bus.rlast = 1'b0; bus.fifo_almost_full = 1'b0;
    #1;
    check("pushes", pushes, v.exp_push);
    check("done", rd_fsm_done, v.exp_done);
    check("rd_error", rd_error, v.exp_err);
    check("beat_count", beat_count, v.exp_bc);
    if (v.exp_done) begin
      @(negedge clk);
      #1;
      check("done_pulse", rd_fsm_done, 0);
      check("busy_after", busy, 0);
    end
    if (v.exp_err) begin
      @(negedge clk);
      bus.rvalid = 1'b1; bus.rresp = 2'd0; bus.rdata = pat(99, 0);
      #1;
      check("err_hold", rd_error, 1);
      check("err_rready", bus.rready, 0);
      check("err_wr_en", bus.fifo_wr_en, 0);
      check("err_busy", busy, 1);
      reset_dispatcher = 1'b1;
      @(negedge clk);
      reset_dispatcher = 1'b0; bus.rvalid = 1'b0;
      #1;
      check("err_clear", rd_error, 0);
      check("err_busy_clr", busy, 0);
      check("bc_hold", beat_count, v.exp_bc);
    end
  endtask

  initial begin
    tbl[0] = '{64'h1000, 8'd3, 0, 1'b0, -1, 4, 1'b1, 4, 1'b1, 1'b0, 9'd4};
    tbl[1] = '{64'h2040, 8'd1, 5, 1'b0, -1, 2, 1'b1, 2, 1'b1, 1'b0, 9'd2};
    tbl[2] = '{64'h8000, 8'd7, 0, 1'b1, -1, 8, 1'b1, 8, 1'b1, 1'b0, 9'd8};
    tbl[3] = '{64'h3000, 8'd3, 0, 1'b0,  1, 4, 1'b1, 3, 1'b0, 1'b1, 9'd4};
    tbl[4] = '{64'h4000, 8'd3, 0, 1'b0, -1, 3, 1'b1, 3, 1'b0, 1'b1, 9'd3};
    tbl[5] = '{64'h4800, 8'd1, 0, 1'b0, -1, 3, 1'b0, 3, 1'b0, 1'b1, 9'd3};

    reset = 1'b1; go = 1'b0; src_addr = '0; length = '0; reset_dispatcher = 1'b0;
    bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rdata = '0; bus.rresp = 2'd0;
    bus.rlast = 1'b0; bus.fifo_almost_full = 1'b0;
    @(negedge clk);
    #1;
    check("rst_arvalid", bus.arvalid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", rd_fsm_done, 0);
    check("rst_err", rd_error, 0);
    check("rst_bc", beat_count, 0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 6; i++) run_vec(tbl[i], i);

    // go held high: one AR per burst, relaunch right after DONE
    @(negedge clk);
    go = 1'b1; src_addr = 64'h5000; length = 8'd0; bus.arready = 1'b1;
    @(negedge clk);
    src_addr = 64'h6000;
    #1 check("b2b_araddr0", bus.araddr, 64'h5000);
    check("b2b_arvalid0", bus.arvalid, 1);
    @(negedge clk);
    bus.rvalid = 1'b1; bus.rlast = 1'b1; bus.rresp = 2'd0; bus.rdata = pat(7, 0);
    #1 check("b2b_arvalid_low", bus.arvalid, 0);
    check("b2b_push", bus.fifo_wr_en, 1);
    @(negedge clk);
    bus.rvalid = 1'b0; bus.rlast = 1'b0; length = 8'd2;
    #1 check("b2b_done", rd_fsm_done, 1);
    check("b2b_single_ar", bus.arvalid, 0);
    @(negedge clk);
    #1 check("b2b_idle", busy, 0);
    check("b2b_done_low", rd_fsm_done, 0);
    @(negedge clk);
    go = 1'b0;
    #1 check("b2b_relaunch", bus.arvalid, 1);
    check("b2b_araddr1", bus.araddr, 64'h6000);
    check("b2b_arlen1", bus.arlen, 2);
    @(negedge clk);
    bus.arready = 1'b0; bus.rvalid = 1'b1; bus.rdata = pat(8, 0);
    #1 check("mid_push0", bus.fifo_wr_en, 1);
    @(negedge clk);
    bus.rdata = pat(8, 1);
    #1 check("mid_push1", bus.fifo_wr_en, 1);
    reset = 1'b1;
    #1;
    check("arst_wr_en", bus.fifo_wr_en, 0);
    check("arst_rready", bus.rready, 0);
    check("arst_busy", busy, 0);
    check("arst_bc", beat_count, 0);
    check("arst_arvalid", bus.arvalid, 0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1 check("post_rst_wr_en", bus.fifo_wr_en, 0);
      check("post_rst_busy", busy, 0);
    end
    bus.rvalid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1);
  end

endmodule

`default_nettype wire
